// File: rtl/dmem_responder.sv
// Data RAM responder for the load/store port: serves one access at a time over
// valid/ready request/response channels, with LATENCY wait cycles per legal access.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state_q;
  logic [3:0]         cnt_q;
  logic               we_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic               valid_q;
  logic               ready_q;
  logic               busy_q;
  logic [31:0]        mem_q [DEPTH];

  logic               req_illegal;
  logic               accept;
  logic               do_access;
  logic [ADDR_W-3:0]  idx;
  logic [31:0]        rd_word;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [31:0]        load_ext;
  logic [3:0]         wr_be;
  logic [31:0]        wr_data;

  always_comb begin
    req_illegal = 1'b0;
    if (req_size == 2'b11)                          req_illegal = 1'b1;
    if (req_size == 2'b01 && req_addr[0])           req_illegal = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b0) req_illegal = 1'b1;
    if (req_addr[31:ADDR_W] != '0)                  req_illegal = 1'b1;
  end

  // ready_q is only ever set while IDLE, so it also gates acceptance to IDLE
  assign accept    = req_valid & ready_q;
  assign do_access = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign idx       = addr_q[ADDR_W-1:2];
  assign rd_word   = mem_q[idx];
  assign rd_byte   = rd_word[{addr_q[1:0], 3'b000} +: 8];
  assign rd_half   = rd_word[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = rd_word;
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_ext = rd_word;
    endcase
  end

  always_comb begin
    wr_be   = 4'b0000;
    wr_data = wdata_q;
    case (size_q)
      2'b00: begin
        wr_be   = 4'b0001 << addr_q[1:0];
        wr_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      2'b10:   wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  // RAM has no reset; rst still blocks the write in the cnt==0 WAIT cycle
  always_ff @(posedge clk) begin
    if (!rst && do_access && we_q) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_be[l]) mem_q[idx][l*8 +: 8] <= wr_data[l*8 +: 8];
      end
    end
  end

  // req_ready rises one cycle after (re)entering IDLE, which sets the
  // 4-cycle cadence for back-to-back requests at LATENCY=0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr[ADDR_W-1:0];
            wdata_q <= req_wdata;
            cnt_q   <= 4'(LATENCY);
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (req_illegal) begin
              state_q <= S_RESP;
              valid_q <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= 32'h0;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= S_RESP;
            valid_q <= 1'b1;
            err_q   <= 1'b0;
            rdata_q <= we_q ? 32'h0 : load_ext;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array reference model with transaction timing,
// random traffic on a LATENCY=2 instance, cadence check on a LATENCY=0 instance.
module tb_dmem_responder;

  localparam int LATA = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_req_valid, a_req_ready, a_req_we, a_req_unsigned;
  logic [1:0]  a_req_size;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic        a_resp_valid, a_resp_ready, a_resp_err, a_busy;
  logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
  logic        b_resp_valid, b_resp_ready, b_resp_err, b_busy;

  dmem_responder #(.ADDR_W(10), .LATENCY(LATA)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_size(a_req_size), .req_unsigned(a_req_unsigned), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .busy(a_busy)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .busy(b_busy)
  );

  int nvec = 0;
  int nerr = 0;
  logic [7:0] ref_mem [1024];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_illegal(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
           (a >= 32'd1024);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] addr);
    int a;
    logic [7:0]  b;
    logic [15:0] h;
    a = int'(addr[9:0]);
    case (sz)
      2'd0: begin
        b = ref_mem[a];
        return uns ? {24'h0, b} : {{24{b[7]}}, b};
      end
      2'd1: begin
        h = {ref_mem[a+1], ref_mem[a]};
        return uns ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endcase
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] addr,
                             input logic [31:0] wd);
    int a;
    a = int'(addr[9:0]);
    for (int i = 0; i < (1 << sz); i++) ref_mem[a+i] = wd[8*i +: 8];
  endtask

  // One complete transaction on the LATENCY=2 instance, checked every cycle.
  // Entered and left on a negedge.
  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd, input int hold,
                     output logic [31:0] got);
    int   lat;
    int   k;
    logic ill;
    logic [31:0] er;
    bit   done;
    got = 32'h0;
    k = 0;
    while (!a_req_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("req_ready_wait", a_req_ready, 1);
    a_req_valid = 1'b1; a_req_we = we; a_req_size = sz; a_req_unsigned = uns;
    a_req_addr = addr; a_req_wdata = wd; a_resp_ready = 1'b0;
    @(posedge clk);
    ill = is_illegal(sz, addr);
    er  = (ill || we) ? 32'h0 : model_load(sz, uns, addr);
    if (!ill && we) model_store(sz, addr, wd);
    lat = ill ? 1 : LATA + 2;
    @(negedge clk);
    // inputs are junk from here on and must be ignored
    a_req_valid = 1'b1; a_req_we = 1'($urandom); a_req_size = 2'($urandom);
    a_req_unsigned = 1'($urandom); a_req_addr = $urandom; a_req_wdata = $urandom;
    done = 0;
    for (k = 1; k <= 40 && !done; k++) begin
      if (k < lat) begin
        chk("resp_valid_early", a_resp_valid, 0);
        chk("busy_wait", a_busy, 1);
        chk("req_ready_wait_state", a_req_ready, 0);
      end else begin
        chk("resp_valid", a_resp_valid, 1);
        chk("resp_rdata", a_resp_rdata, er);
        chk("resp_err", a_resp_err, 32'(ill));
        chk("busy_resp", a_busy, 1);
        chk("req_ready_resp", a_req_ready, 0);
        got = a_resp_rdata;
        if (k - lat == hold) begin
          a_resp_ready = 1'b1;
          @(negedge clk);
          chk("post_valid", a_resp_valid, 0);
          chk("post_rdata", a_resp_rdata, 0);
          chk("post_err", a_resp_err, 0);
          chk("post_busy", a_busy, 0);
          chk("post_ready", a_req_ready, 0);
          a_resp_ready = 1'b0;
          a_req_valid  = 1'b0;
          done = 1;
        end
      end
      if (!done) @(negedge clk);
    end
    if (!done) begin
      nvec++; nerr++;
      $display("FAIL resp_timeout: no handshake within 40 cycles at %0t", $time);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, v, addr, prev;
    logic [1:0]  sz;
    int          ph, k;
    rst = 1'b1;
    a_req_valid = 0; a_req_we = 0; a_req_size = 0; a_req_unsigned = 0;
    a_req_addr = 0; a_req_wdata = 0; a_resp_ready = 0;
    b_req_valid = 0; b_req_we = 0; b_req_size = 0; b_req_unsigned = 0;
    b_req_addr = 0; b_req_wdata = 0; b_resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", a_resp_valid, 0);
    chk("rst_rdata", a_resp_rdata, 0);
    chk("rst_err", a_resp_err, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_ready", a_req_ready, 0);
    rst = 1'b0;
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_size = 2'd2;
    b_req_addr = 32'h40; b_req_wdata = 32'h8899AABB;
    @(negedge clk);
    chk("rst_ready_next", a_req_ready, 1);

    // T6: LATENCY=0, req_valid held, resp_ready tied: store then loads every 4 cycles
    for (int i = 0; i <= 16; i++) begin
      ph = i % 4;
      chk("t6_ready", b_req_ready, 32'(ph == 0));
      chk("t6_busy", b_busy, 32'(ph == 1 || ph == 2));
      chk("t6_valid", b_resp_valid, 32'(ph == 2));
      chk("t6_rdata", b_resp_rdata, (ph == 2 && i != 2) ? 32'h8899AABB : 32'h0);
      chk("t6_err", b_resp_err, 0);
      if (i == 1) begin
        b_req_we = 1'b0; b_req_wdata = 32'h0;
      end
      if (i == 16) b_req_valid = 1'b0;
      if (i < 16) @(negedge clk);
    end

    // fill the RAM so every later load has a defined reference
    for (int w = 0; w < 256; w++) txn(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 0, got);

    // T1
    txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, got);
    chk("t1_store_rdata", got, 32'h0);
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, got);
    chk("t1_load", got, 32'hDEADBEEF);
    // T2
    txn(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, 1, got);
    txn(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 0, got);
    chk("t2_sbyte", got, 32'hFFFFFFAA);
    txn(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 0, got);
    chk("t2_ubyte", got, 32'h000000AA);
    txn(1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 0, got);
    chk("t2_word", got, 32'hDEADAAEF);
    txn(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, got);
    chk("t2_uhalf", got, 32'h0000DEAD);
    // T3
    txn(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 0, got);
    chk("t3_misaligned_rdata", got, 32'h0);
    prev = model_load(2'd2, 1'b0, 32'h0);
    txn(1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFEF00D, 0, got);
    txn(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0, got);
    chk("t3_ram_unchanged", got, prev);
    txn(1'b0, 2'd3, 1'b0, 32'h8, 32'h0, 0, got);
    // T4: response held for 5 cycles while junk requests are offered
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, got);
    chk("t4_load", got, 32'hDEADAAEF);

    // T5: reset in the cnt==0 WAIT cycle aborts the store
    txn(1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 0, got);
    k = 0;
    while (!a_req_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_size = 2'd2;
    a_req_addr = 32'h20; a_req_wdata = 32'h12345678;
    @(negedge clk);
    a_req_valid = 1'b0;
    chk("t5_busy", a_busy, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_valid", a_resp_valid, 0);
    chk("t5_rdata", a_resp_rdata, 0);
    chk("t5_err", a_resp_err, 0);
    chk("t5_busy_clear", a_busy, 0);
    rst = 1'b0;
    txn(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, got);
    chk("t5_load", got, 32'h00000000);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      sz = 2'($urandom_range(0, 3));
      addr = 32'($urandom_range(0, 1279));
      if ($urandom_range(0, 4) != 0) begin
        if (sz == 2'd2) addr = addr & 32'hFFFF_FFFC;
        if (sz == 2'd1) addr = addr & 32'hFFFF_FFFE;
      end
      if ($urandom_range(0, 15) == 0) addr[31:28] = 4'($urandom_range(1, 15));
      v = $urandom;
      txn(1'($urandom), sz, 1'($urandom), addr, v, $urandom_range(0, 3), got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
